// File: rtl/pixel_timing_gen.sv
// Pixel timing generator: programmable clock divider driving pixel/line/frame counters.
// Define PIXEL_TIMING_FRAME_EN to build the line counter (pix_y, frame_done); otherwise both are tied to 0.
module pixel_timing_gen #(
  parameter int unsigned DIV_W       = 4,
  parameter int unsigned DIV_DEFAULT = 5,
  parameter int unsigned PIX_W       = 10,
  parameter int unsigned LINE_W      = 10
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              enable,
  input  logic              clear,
  input  logic [DIV_W-1:0]  div_val,
  input  logic [PIX_W-1:0]  pix_per_line,
  input  logic [LINE_W-1:0] lines_per_frame,
  output logic              flag_pixel,
  output logic              pix_strobe,
  output logic [PIX_W-1:0]  pix_x,
  output logic              line_done,
  output logic [LINE_W-1:0] pix_y,
  output logic              frame_done
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_next;
  logic [PIX_W-1:0] pix_last;
  logic             pix_event;
  logic             line_wrap;

  // Zero lengths behave as 1; pix_x == pix_last is an exact match, so a lowered
  // line length lets pix_x run on to its width maximum and wrap without a pulse.
  always_comb begin
    div_next  = (div_val == '0) ? DIV_W'(1) : div_val;
    pix_last  = (pix_per_line == '0) ? '0 : pix_per_line - PIX_W'(1);
    pix_event = enable && (cnt == div_reg - DIV_W'(1));
    line_wrap = pix_event && (pix_x == pix_last);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt        <= '0;
      div_reg    <= DIV_W'(DIV_DEFAULT);
      flag_pixel <= 1'b0;
      pix_strobe <= 1'b0;
      pix_x      <= '0;
      line_done  <= 1'b0;
    end else if (clear) begin
      cnt        <= '0;
      div_reg    <= div_next;
      flag_pixel <= 1'b0;
      pix_strobe <= 1'b0;
      pix_x      <= '0;
      line_done  <= 1'b0;
    end else begin
      pix_strobe <= pix_event;
      line_done  <= line_wrap;
      if (pix_event) begin
        cnt        <= '0;
        div_reg    <= div_next;
        flag_pixel <= ~flag_pixel;
        pix_x      <= line_wrap ? '0 : pix_x + PIX_W'(1);
      end else if (enable) begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

`ifdef PIXEL_TIMING_FRAME_EN
  logic [LINE_W-1:0] line_last;
  logic              frame_wrap;

  always_comb begin
    line_last  = (lines_per_frame == '0) ? '0 : lines_per_frame - LINE_W'(1);
    frame_wrap = line_wrap && (pix_y == line_last);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pix_y      <= '0;
      frame_done <= 1'b0;
    end else if (clear) begin
      pix_y      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_wrap;
      if (line_wrap) begin
        pix_y <= frame_wrap ? '0 : pix_y + LINE_W'(1);
      end
    end
  end
`else
  logic unused_lines;
  assign unused_lines = ^lines_per_frame;
  assign pix_y        = '0;
  assign frame_done   = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_timing_gen.sv
// Directed + randomized bench for pixel_timing_gen against an event-count reference model.
module tb_pixel_timing_gen;
  localparam int unsigned DIV_W       = 4;
  localparam int unsigned DIV_DEFAULT = 5;
  localparam int unsigned PIX_W       = 10;
  localparam int unsigned LINE_W      = 10;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              enable;
  logic              clear;
  logic [DIV_W-1:0]  div_val;
  logic [PIX_W-1:0]  pix_per_line;
  logic [LINE_W-1:0] lines_per_frame;
  logic              flag_pixel;
  logic              pix_strobe;
  logic [PIX_W-1:0]  pix_x;
  logic              line_done;
  logic [LINE_W-1:0] pix_y;
  logic              frame_done;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  // Model state: enabled cycles into the current period, its length, and total pixel events.
  int m_phase;
  int m_period;
  int m_events;
  bit m_strobe;
  bit m_line;
  bit m_frame;

  always #5 clk = ~clk;

  pixel_timing_gen #(
    .DIV_W(DIV_W),
    .DIV_DEFAULT(DIV_DEFAULT),
    .PIX_W(PIX_W),
    .LINE_W(LINE_W)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .enable(enable),
    .clear(clear),
    .div_val(div_val),
    .pix_per_line(pix_per_line),
    .lines_per_frame(lines_per_frame),
    .flag_pixel(flag_pixel),
    .pix_strobe(pix_strobe),
    .pix_x(pix_x),
    .line_done(line_done),
    .pix_y(pix_y),
    .frame_done(frame_done)
  );

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_period = DIV_DEFAULT;
    m_events = 0;
    m_strobe = 1'b0;
    m_line   = 1'b0;
    m_frame  = 1'b0;
  endtask

  task automatic model_edge();
    int ppl;
    int lpf;
    ppl = eff(int'(pix_per_line));
    lpf = eff(int'(lines_per_frame));
    m_strobe = 1'b0;
    m_line   = 1'b0;
    m_frame  = 1'b0;
    if (clear) begin
      m_phase  = 0;
      m_period = eff(int'(div_val));
      m_events = 0;
    end else if (enable) begin
      m_phase++;
      if (m_phase == m_period) begin
        m_phase  = 0;
        m_period = eff(int'(div_val));
        m_events++;
        m_strobe = 1'b1;
        m_line   = (m_events % ppl) == 0;
        m_frame  = (m_events % (ppl * lpf)) == 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int ppl;
    int lpf;
    ppl = eff(int'(pix_per_line));
    lpf = eff(int'(lines_per_frame));
    cmp({tag, ".flag"}, 32'(flag_pixel), 32'(m_events % 2));
    cmp({tag, ".strobe"}, 32'(pix_strobe), 32'(m_strobe));
    cmp({tag, ".line_done"}, 32'(line_done), 32'(m_line));
    cmp({tag, ".pix_x"}, 32'(pix_x), 32'(m_events % ppl));
`ifdef PIXEL_TIMING_FRAME_EN
    cmp({tag, ".pix_y"}, 32'(pix_y), 32'((m_events / ppl) % lpf));
    cmp({tag, ".frame_done"}, 32'(frame_done), 32'(m_frame));
`else
    cmp({tag, ".pix_y"}, 32'(pix_y), 32'd0);
    cmp({tag, ".frame_done"}, 32'(frame_done), 32'd0);
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic wait_strobe(input string tag, output int n);
    n = 0;
    do begin
      step(tag);
      n++;
    end while (!pix_strobe && n < 20);
  endtask

  task automatic all_zero(input string tag);
    cmp({tag, ".flag"}, 32'(flag_pixel), 32'd0);
    cmp({tag, ".strobe"}, 32'(pix_strobe), 32'd0);
    cmp({tag, ".pix_x"}, 32'(pix_x), 32'd0);
    cmp({tag, ".line_done"}, 32'(line_done), 32'd0);
    cmp({tag, ".pix_y"}, 32'(pix_y), 32'd0);
    cmp({tag, ".frame_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    int n;
    int cnt_a;
    int cnt_b;
    n_rst           = 1'b0;
    enable          = 1'b0;
    clear           = 1'b0;
    div_val         = 4'd5;
    pix_per_line    = 10'd10;
    lines_per_frame = 10'd8;
    #12;
    all_zero("reset");
    model_reset();
    n_rst = 1'b1;

    // Steady divide-by-5: six strobes in 30 cycles.
    enable = 1'b1;
    cnt_a  = 0;
    for (int i = 0; i < 30; i++) begin
      step("div5");
      cnt_a += int'(pix_strobe);
    end
    cmp("div5_strobe_count", 32'(cnt_a), 32'd6);

    // Divide-by-1 with a 4x3 frame.
    clear           = 1'b1;
    div_val         = 4'd1;
    pix_per_line    = 10'd4;
    lines_per_frame = 10'd3;
    step("frame_clear");
    clear = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 24; i++) begin
      step("frame");
      cnt_a += int'(line_done);
      cnt_b += int'(frame_done);
    end
    cmp("frame_line_count", 32'(cnt_a), 32'd6);
`ifdef PIXEL_TIMING_FRAME_EN
    cmp("frame_frame_count", 32'(cnt_b), 32'd2);
`else
    cmp("frame_frame_count", 32'(cnt_b), 32'd0);
`endif

    // Ratio change mid-period takes effect only after the current event.
    clear           = 1'b1;
    div_val         = 4'd5;
    pix_per_line    = 10'd10;
    lines_per_frame = 10'd8;
    step("ratio_clear");
    clear = 1'b0;
    step("ratio");
    step("ratio");
    div_val = 4'd3;
    wait_strobe("ratio", n);
    cmp("ratio_first", 32'(n), 32'd3);
    wait_strobe("ratio", n);
    cmp("ratio_second", 32'(n), 32'd3);
    div_val = 4'd0;
    wait_strobe("ratio", n);
    cmp("ratio_to_zero", 32'(n), 32'd3);
    step("ratio_zero");
    cmp("ratio_zero_strobe", 32'(pix_strobe), 32'd1);

    // Clear with enable at cnt=3, pix_x=2.
    clear   = 1'b1;
    div_val = 4'd5;
    step("clr_setup");
    clear = 1'b0;
    for (int i = 0; i < 13; i++) step("clr_run");
    cmp("clr_pre_x", 32'(pix_x), 32'd2);
    clear = 1'b1;
    step("clr_hit");
    clear = 1'b0;
    all_zero("clr_hit");
    wait_strobe("clr_after", n);
    cmp("clr_after_period", 32'(n), 32'd5);

    // Enable gap delays the event by the gap length.
    clear = 1'b1;
    step("gap_clear");
    clear = 1'b0;
    step("gap");
    step("gap");
    enable = 1'b0;
    for (int i = 0; i < 3; i++) step("gap_low");
    enable = 1'b1;
    wait_strobe("gap", n);
    cmp("gap_delay", 32'(n), 32'd3);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) begin
        clear           = 1'b1;
        pix_per_line    = 10'($urandom_range(0, 6));
        lines_per_frame = 10'($urandom_range(0, 4));
      end else begin
        clear = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) div_val = 4'($urandom_range(0, 15));
      step("rand");
    end

    // Asynchronous reset mid-frame; first event uses the reset ratio, not div_val.
    clear           = 1'b1;
    enable          = 1'b1;
    div_val         = 4'd2;
    pix_per_line    = 10'd3;
    lines_per_frame = 10'd4;
    step("rst_setup");
    clear = 1'b0;
    for (int i = 0; i < 9; i++) step("rst_run");
    div_val = 4'd3;
    #2;
    n_rst = 1'b0;
    #1;
    all_zero("rst_async");
    model_reset();
    #2;
    n_rst = 1'b1;
    wait_strobe("rst_after", n);
    cmp("rst_first_strobe", 32'(n), 32'(DIV_DEFAULT));
    wait_strobe("rst_after", n);
    cmp("rst_second_strobe", 32'(n), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
